// File: rtl/cov_pkg.sv
// Shared types and elaboration-time helpers for the toggle-coverage scanner.
package cov_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } cov_state_e;

    // Integer ceiling division, used to size the number of output words.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // clog2 that never returns 0, so a single-word dump still gets a 1-bit index.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/cov_popcount.sv
// Combinational population count built as a recursive binary adder tree.
module cov_popcount #(
    parameter int W  = 8,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [OW-1:0] count
);

    generate
        if (W == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_node
            localparam int LW  = W / 2;
            localparam int HW  = W - LW;
            localparam int LOW = $clog2(LW + 1);
            localparam int HOW = $clog2(HW + 1);

            logic [LOW-1:0] lo_count;
            logic [HOW-1:0] hi_count;

            cov_popcount #(.W(LW), .OW(LOW)) u_lo (
                .bits  (bits[LW-1:0]),
                .count (lo_count)
            );

            cov_popcount #(.W(HW), .OW(HOW)) u_hi (
                .bits  (bits[W-1:LW]),
                .count (hi_count)
            );

            assign count = OW'(lo_count) + OW'(hi_count);
        end
    endgenerate

endmodule

// File: rtl/cov_scan_ctrl.sv
// Toggle-coverage collector: accumulates a sticky toggle bitmap of the probed
// state and streams it out in CHUNK-bit words on request.
module cov_scan_ctrl
    import cov_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int CHUNK  = 32,
    // Derived widths; leave at their defaults.
    parameter int NCHUNK = ceil_div(WIDTH, CHUNK),
    parameter int IDXW   = clog2_min1(NCHUNK),
    parameter int CNTW   = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] state,
    input  logic             clear,
    input  logic             dump_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHUNK-1:0] out_data,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  cov_count
);

    localparam int PADW = NCHUNK * CHUNK;

    cov_state_e         state_reg, state_next;
    logic [IDXW-1:0]    ptr_reg, ptr_next;
    logic [WIDTH-1:0]   bitmap_reg;
    logic [WIDTH-1:0]   prev_reg;
    logic               primed_reg;
    logic [CNTW-1:0]    count_reg;

    logic               do_clear;
    logic               do_sample;
    logic [WIDTH-1:0]   toggles;
    logic [WIDTH-1:0]   new_bits;
    logic [CNTW-1:0]    new_count;
    logic [PADW-1:0]    padded;
    logic               is_last;

    // Only bits that toggled and were not yet covered add to the count.
    assign toggles  = prev_reg ^ state;
    assign new_bits = toggles & ~bitmap_reg;
    assign is_last  = (ptr_reg == IDXW'(NCHUNK - 1));

    cov_popcount #(.W(WIDTH), .OW(CNTW)) u_popcount (
        .bits  (new_bits),
        .count (new_count)
    );

    // Zero-extend the bitmap to a whole number of words so the final word pads with 0.
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = bitmap_reg;
    end

    // Next-state, control decode and output generation.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        do_clear   = 1'b0;
        do_sample  = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    do_clear = 1'b1;
                end else if (dump_req) begin
                    state_next = DRAIN;
                    ptr_next   = '0;
                end else if (sample_en) begin
                    do_sample = 1'b1;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = padded[ptr_reg*CHUNK +: CHUNK];
                out_idx   = ptr_reg;
                out_last  = is_last;
                if (out_ready) begin
                    if (is_last) begin
                        state_next = DONE;
                    end else begin
                        ptr_next = ptr_reg + IDXW'(1);
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign cov_count = count_reg;

    // FSM state and word pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Coverage datapath: the first sample after reset/clear only primes the reference.
    always_ff @(posedge clock) begin
        if (reset) begin
            bitmap_reg <= '0;
            prev_reg   <= '0;
            primed_reg <= 1'b0;
            count_reg  <= '0;
        end else if (do_clear) begin
            bitmap_reg <= '0;
            primed_reg <= 1'b0;
            count_reg  <= '0;
        end else if (do_sample) begin
            prev_reg <= state;
            if (!primed_reg) begin
                primed_reg <= 1'b1;
            end else begin
                bitmap_reg <= bitmap_reg | toggles;
                count_reg  <= count_reg + new_count;
            end
        end
    end

endmodule

// File: tb/tb_cov_scan_ctrl.sv
// Directed self-checking bench for cov_scan_ctrl (256/32 and 40/32 configurations).
module tb_cov_scan_ctrl;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    // Instance A: WIDTH=256, CHUNK=32
    logic         a_sample_en, a_clear, a_dump_req, a_out_ready;
    logic [255:0] a_state;
    logic         a_out_valid, a_out_last, a_busy, a_done;
    logic [31:0]  a_out_data;
    logic [2:0]   a_out_idx;
    logic [8:0]   a_cov_count;

    // Instance B: WIDTH=40, CHUNK=32
    logic         b_sample_en, b_clear, b_dump_req, b_out_ready;
    logic [39:0]  b_state;
    logic         b_out_valid, b_out_last, b_busy, b_done;
    logic [31:0]  b_out_data;
    logic [0:0]   b_out_idx;
    logic [5:0]   b_cov_count;

    cov_scan_ctrl #(.WIDTH(256), .CHUNK(32)) u_dut_a (
        .clock(clock), .reset(reset), .sample_en(a_sample_en), .state(a_state),
        .clear(a_clear), .dump_req(a_dump_req), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_idx(a_out_idx),
        .out_last(a_out_last), .busy(a_busy), .done(a_done), .cov_count(a_cov_count)
    );

    cov_scan_ctrl #(.WIDTH(40), .CHUNK(32)) u_dut_b (
        .clock(clock), .reset(reset), .sample_en(b_sample_en), .state(b_state),
        .clear(b_clear), .dump_req(b_dump_req), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_idx(b_out_idx),
        .out_last(b_out_last), .busy(b_busy), .done(b_done), .cov_count(b_cov_count)
    );

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_sample_en = 0; a_clear = 0; a_dump_req = 0; a_out_ready = 0; a_state = '0;
        b_sample_en = 0; b_clear = 0; b_dump_req = 0; b_out_ready = 0; b_state = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One sample on instance A.
    task automatic sample_a(input logic [255:0] value);
        a_sample_en = 1'b1;
        a_state     = value;
        tick();
        a_sample_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b last=%b, required all 0",
                     a_out_valid, a_busy, a_done, a_out_last);
        end
        checks++;
        if (a_cov_count !== 9'd0 || a_out_data !== 32'd0 || a_out_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: cov=%0d data=%h idx=%0d, required 0/0/0",
                     a_cov_count, a_out_data, a_out_idx);
        end
    endtask

    task automatic test_basic_toggle();
        do_reset();
        sample_a(256'h0);
        checks++;
        if (a_cov_count !== 9'd0) begin
            errors++;
            $display("FAIL basic_ref: cov=%0d required 0", a_cov_count);
        end
        sample_a(256'h5);
        checks++;
        if (a_cov_count !== 9'd2 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_0x5: cov=%0d valid=%b required 2/0", a_cov_count, a_out_valid);
        end
    endtask

    // Relies on bitmap=0x5 left by test_basic_toggle.
    task automatic test_dump();
        logic [31:0] exp_data;
        a_dump_req  = 1'b1;
        a_out_ready = 1'b1;
        tick();
        a_dump_req  = 1'b0;
        a_sample_en = 1'b1;
        a_state     = '1;
        for (int i = 0; i < 8; i++) begin
            exp_data = (i == 0) ? 32'h5 : 32'h0;
            checks++;
            if (a_out_valid !== 1'b1 || a_out_idx !== 3'(i) || a_out_data !== exp_data ||
                a_out_last !== (i == 7)) begin
                errors++;
                $display("FAIL dump_word%0d: valid=%b idx=%0d data=%h last=%b required 1/%0d/%h/%b",
                         i, a_out_valid, a_out_idx, a_out_data, a_out_last, i, exp_data, (i == 7));
            end
            $display("dump word idx=%0d data=%h last=%b", a_out_idx, a_out_data, a_out_last);
            tick();
        end
        checks++;
        if (a_done !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL dump_done: done=%b valid=%b busy=%b required 1/0/1", a_done, a_out_valid, a_busy);
        end
        a_sample_en = 1'b0;
        tick();
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_cov_count !== 9'd2) begin
            errors++;
            $display("FAIL dump_after: done=%b busy=%b cov=%0d required 0/0/2", a_done, a_busy, a_cov_count);
        end
    endtask

    task automatic test_first_sample();
        do_reset();
        sample_a('1);
        checks++;
        if (a_cov_count !== 9'd0) begin
            errors++;
            $display("FAIL first_ref: cov=%0d required 0", a_cov_count);
        end
        sample_a('0);
        checks++;
        if (a_cov_count !== 9'd256) begin
            errors++;
            $display("FAIL first_full: cov=%0d required 256", a_cov_count);
        end
    endtask

    task automatic test_repeat_toggle();
        logic [255:0] seq [4];
        seq[0] = 256'h0; seq[1] = 256'h1; seq[2] = 256'h0; seq[3] = 256'h1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sample_a(seq[i]);
            checks++;
            if (a_cov_count !== ((i == 0) ? 9'd0 : 9'd1)) begin
                errors++;
                $display("FAIL repeat_%0d: cov=%0d required %0d", i, a_cov_count, (i == 0) ? 0 : 1);
            end
        end
        // prev=0x1; a disabled cycle must not move the reference.
        a_sample_en = 1'b0;
        a_state     = 256'h2;
        tick();
        sample_a(256'h1);
        checks++;
        if (a_cov_count !== 9'd1) begin
            errors++;
            $display("FAIL hold_prev: cov=%0d required 1", a_cov_count);
        end
        sample_a(256'h3);
        checks++;
        if (a_cov_count !== 9'd2) begin
            errors++;
            $display("FAIL hold_next: cov=%0d required 2", a_cov_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        b_sample_en = 1'b1; b_state = '0; tick();
        b_state = '1; tick();
        b_sample_en = 1'b0;
        checks++;
        if (b_cov_count !== 6'd40) begin
            errors++;
            $display("FAIL stall_cov: cov=%0d required 40", b_cov_count);
        end
        b_dump_req = 1'b1; b_out_ready = 1'b0; tick();
        b_dump_req = 1'b0;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (b_out_valid !== 1'b1 || b_out_idx !== 1'd0 || b_out_data !== 32'hFFFF_FFFF || b_out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_w0_%0d: valid=%b idx=%0d data=%h last=%b required 1/0/ffffffff/0",
                         s, b_out_valid, b_out_idx, b_out_data, b_out_last);
            end
            if (s == 0) tick();
        end
        b_out_ready = 1'b1;
        $display("stall word idx=%0d data=%h last=%b", b_out_idx, b_out_data, b_out_last);
        tick();
        b_out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (b_out_valid !== 1'b1 || b_out_idx !== 1'd1 || b_out_data !== 32'h0000_00FF || b_out_last !== 1'b1) begin
                errors++;
                $display("FAIL stall_w1_%0d: valid=%b idx=%0d data=%h last=%b required 1/1/000000ff/1",
                         s, b_out_valid, b_out_idx, b_out_data, b_out_last);
            end
            if (s == 0) tick();
        end
        b_out_ready = 1'b1;
        $display("stall word idx=%0d data=%h last=%b", b_out_idx, b_out_data, b_out_last);
        tick();
        b_out_ready = 1'b0;
        checks++;
        if (b_done !== 1'b1 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b valid=%b required 1/0", b_done, b_out_valid);
        end
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        sample_a(256'h0);
        sample_a(256'h5);
        a_dump_req = 1'b1; a_out_ready = 1'b1; tick();
        a_dump_req = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (a_out_idx !== 3'd3 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_idx: idx=%0d valid=%b required 3/1", a_out_idx, a_out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_cov_count !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b cov=%0d required 0/0/0", a_out_valid, a_busy, a_cov_count);
        end
    endtask

    task automatic test_clear_priority();
        sample_a(256'h0);
        sample_a(256'h5);
        a_clear = 1'b1; a_dump_req = 1'b1; a_sample_en = 1'b1; a_state = 256'hFF;
        tick();
        a_clear = 1'b0; a_dump_req = 1'b0; a_sample_en = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_cov_count !== 9'd0) begin
            errors++;
            $display("FAIL clear_prio: busy=%b valid=%b cov=%0d required 0/0/0", a_busy, a_out_valid, a_cov_count);
        end
        sample_a(256'h3);
        checks++;
        if (a_cov_count !== 9'd0) begin
            errors++;
            $display("FAIL clear_unprime: cov=%0d required 0", a_cov_count);
        end
        sample_a(256'h0);
        checks++;
        if (a_cov_count !== 9'd2) begin
            errors++;
            $display("FAIL clear_resume: cov=%0d required 2", a_cov_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_toggle();
        test_dump();
        test_first_sample();
        test_repeat_toggle();
        test_stall();
        test_reset_mid_dump();
        test_clear_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cov_scan_ctrl.md
Name: cov_scan_ctrl

Overview:
- Toggle-coverage collector and dump sequencer for the probed ASIC state vector.
- Each sampled cycle it XORs the state against the previous sample and ORs the toggles into a sticky coverage bitmap.
- It keeps a running count of covered bits.
- On request it freezes sampling and streams the bitmap out in CHUNK-bit words over a valid/ready port, which feeds the testbench or an on-chip trace buffer.

Parameters:
- WIDTH, 256, probed state width in bits (>=1).
- CHUNK, 32, output word width in bits (>=1).
- NCHUNK, derived ceil(WIDTH/CHUNK), number of output words.
- IDXW, derived max(1, clog2(NCHUNK)), output index width.
- CNTW, derived clog2(WIDTH+1), coverage count width.

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- sample_en  input  1  sample state this cycle.
- state  input  WIDTH  probed state vector.
- clear  input  1  zero the bitmap and count; honoured only in IDLE.
- dump_req  input  1  start a dump; honoured only in IDLE.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  CHUNK  bitmap word.
- out_idx  output  IDXW  word index, 0..NCHUNK-1.
- out_last  output  1  asserted with the final word.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.
- cov_count  output  CNTW  number of bits set in the bitmap.

Behaviour:
- Reset values: all outputs 0. The internal bitmap, prev_state, primed flag, chunk pointer and FSM state are also cleared; FSM goes to IDLE.
- Sampling happens only in IDLE with sample_en=1.
  - If primed=0: prev_state<=state, primed<=1, bitmap unchanged. The first sample after reset or clear is reference-only.
  - If primed=1: tog=prev_state^state; new=tog&~bitmap; bitmap<=bitmap|tog; cov_count<=cov_count+popcount(new); prev_state<=state.
  - Updates are visible on outputs the cycle after the sampling edge (1-cycle latency).
- sample_en=0 holds prev_state, so the next toggle is computed against the last sampled value.
- clear in IDLE zeroes bitmap, cov_count and primed. Priority in IDLE: clear > dump_req > sampling. A same-cycle sample is dropped.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE -> DRAIN on dump_req with clear=0. The pointer is set to 0.
  - DRAIN:
    - out_valid=1.
    - out_data = bitmap[ptr*CHUNK +: CHUNK]. Bits at or above WIDTH in the final chunk read 0.
    - out_idx=ptr; out_last=(ptr==NCHUNK-1).
    - On out_valid&out_ready: if last, go to DONE; else ptr<=ptr+1.
    - With out_ready low, out_data, out_idx and out_last hold stable.
  - DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
- In DRAIN and DONE: sampling is frozen (bitmap, prev_state and cov_count held), and clear and dump_req are ignored.
- The dump does not clear the bitmap. A later dump re-emits the accumulated map.
- cov_count saturates naturally at WIDTH, since new bits can never exceed the unset bits.
- Reset in any state, including mid-DRAIN, aborts immediately. The cycle after, out_valid=0 and busy=0.

Decomposition:
- Shared package cov_pkg holds:
  - the typedef cov_state_e {IDLE, DRAIN, DONE};
  - localparam functions for NCHUNK, IDXW and CNTW (ceil-div, clog2 wrapper).
- One sub-module, cov_popcount (parameterised width, combinational adder tree), computes popcount(new).
- Chunk selection stays inline.

Test Plan:
- Reset, then sample state=0, then state=0x5 (WIDTH=256) -> bitmap bit0 and bit2 set, cov_count=2; no out_valid.
- First sample after reset with state=all-ones -> cov_count stays 0 (reference only). Next sample of 0 -> cov_count=256.
- Same bit toggled repeatedly (0x1, 0x0, 0x1) -> cov_count=1, not 3.
- dump_req with out_ready=1 and bitmap=0x5 -> 8 words, idx 0..7, word0=0x00000005, others 0, out_last on idx 7. done pulses one cycle after the idx-7 handshake; sampling during the dump leaves cov_count unchanged.
- WIDTH=40, CHUNK=32, all bits covered, out_ready toggled 1/0 -> 2 words. Data holds across stalls; word1=0x000000FF (pad bits 0).
- Reset asserted with out_idx=3 mid-dump -> next cycle out_valid=0, busy=0, cov_count=0. Then clear+dump_req together in IDLE -> clear wins, no dump.
